// File: rtl/b_powermonitor_scan_sequencer.sv
// Power Monitor ADC scan sequencer: steps the analog mux over the converter channels,
// fetches each channel's thresholds, triggers one conversion and grades the sample.
module b_powermonitor_scan_sequencer #(
    parameter int NumConverters = 8,
    parameter int DataWidth     = 12,
    parameter int SettleCycles  = 4,
    parameter int TimeoutCycles = 255
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   enable,
    input  logic                   clear_err,
    output logic [4:0]             chan_sel,
    output logic                   thr_rd,
    output logic [4:0]             thr_addr,
    input  logic [4*DataWidth-1:0] thr_data,
    output logic                   adc_soc,
    input  logic                   adc_done,
    input  logic [DataWidth-1:0]   adc_data,
    output logic [31:0]            pgood_bus,
    output logic                   warn,
    output logic                   fault,
    output logic                   eoc,
    output logic                   timeout_err
);

    localparam int SCW = (SettleCycles > 2) ? $clog2(SettleCycles) : 1;
    localparam logic [SCW-1:0] SettleLast  = SCW'(SettleCycles - 1);
    localparam logic [7:0]     TimeoutLast = 8'(TimeoutCycles - 1);
    localparam logic [4:0]     LastChan    = 5'(NumConverters - 1);

    typedef enum logic [2:0] {IDLE, SETTLE, CONVERT, WAIT, EVAL} state_t;

    state_t               state, state_next;
    logic [4:0]           chan, chan_next;
    logic [SCW-1:0]       settle_cnt, settle_cnt_next;
    logic [7:0]           wait_cnt, wait_cnt_next;
    logic                 capture_sample, timeout_hit, eval_last;
    logic [DataWidth-1:0] sample;
    logic [DataWidth-1:0] ov_fault_thr, ov_warn_thr, uv_warn_thr, uv_fault_thr;
    logic                 tmo_flag;
    logic                 fault_i, warn_i;
    logic [31:0]          warn_vec, fault_vec;
    logic [31:0]          pgood_next, warn_next, fault_next;

    always_comb begin
        state_next      = state;
        chan_next       = chan;
        settle_cnt_next = settle_cnt;
        wait_cnt_next   = wait_cnt;
        capture_sample  = 1'b0;
        timeout_hit     = 1'b0;
        eval_last       = 1'b0;
        case (state)
            IDLE: begin
                chan_next = 5'd0;
                if (enable) begin
                    state_next      = SETTLE;
                    settle_cnt_next = '0;
                end
            end
            SETTLE: begin
                if (settle_cnt == SettleLast) state_next = CONVERT;
                else settle_cnt_next = settle_cnt + SCW'(1);
            end
            CONVERT: begin
                wait_cnt_next = 8'd0;
                state_next    = WAIT;
            end
            WAIT: begin
                // A done strobe on the final allowed cycle still counts as a real sample
                if (adc_done) begin
                    capture_sample = 1'b1;
                    state_next     = EVAL;
                end else if (wait_cnt == TimeoutLast) begin
                    timeout_hit = 1'b1;
                    state_next  = EVAL;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            EVAL: begin
                settle_cnt_next = '0;
                if (chan == LastChan) begin
                    eval_last  = 1'b1;
                    chan_next  = 5'd0;
                    state_next = enable ? SETTLE : IDLE;
                end else if (enable) begin
                    chan_next  = chan + 5'd1;
                    state_next = SETTLE;
                end else begin
                    chan_next  = 5'd0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fault_i    = tmo_flag || (sample >= ov_fault_thr) || (sample <= uv_fault_thr);
        warn_i     = !fault_i && ((sample >= ov_warn_thr) || (sample <= uv_warn_thr));
        pgood_next = pgood_bus;
        warn_next  = warn_vec;
        fault_next = fault_vec;
        if (state == EVAL && 32'(chan) < NumConverters) begin
            pgood_next[chan] = !fault_i;
            warn_next[chan]  = warn_i;
            fault_next[chan] = fault_i;
        end
    end

    // Outputs are registered from the next-state decode so they line up with the state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            chan         <= 5'd0;
            settle_cnt   <= '0;
            wait_cnt     <= 8'd0;
            chan_sel     <= 5'd0;
            thr_addr     <= 5'd0;
            thr_rd       <= 1'b0;
            adc_soc      <= 1'b0;
            eoc          <= 1'b0;
            pgood_bus    <= 32'd0;
            warn_vec     <= 32'd0;
            fault_vec    <= 32'd0;
            warn         <= 1'b0;
            fault        <= 1'b0;
            sample       <= '0;
            tmo_flag     <= 1'b0;
            ov_fault_thr <= '0;
            ov_warn_thr  <= '0;
            uv_warn_thr  <= '0;
            uv_fault_thr <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state      <= state_next;
            chan       <= chan_next;
            settle_cnt <= settle_cnt_next;
            wait_cnt   <= wait_cnt_next;
            chan_sel   <= chan_next;
            thr_addr   <= chan_next;
            thr_rd     <= (state_next == SETTLE) && (state != SETTLE);
            adc_soc    <= (state_next == CONVERT);
            eoc        <= eval_last;
            pgood_bus  <= pgood_next;
            warn_vec   <= warn_next;
            fault_vec  <= fault_next;
            warn       <= |warn_next;
            fault      <= |fault_next;
            if (capture_sample) begin
                sample   <= adc_data;
                tmo_flag <= 1'b0;
            end else if (timeout_hit) begin
                tmo_flag <= 1'b1;
            end
            // RAM data arrives one cycle after the read strobe of the first settle cycle
            if (state == SETTLE && settle_cnt == SCW'(1))
                {ov_fault_thr, ov_warn_thr, uv_warn_thr, uv_fault_thr} <= thr_data;
            if (timeout_hit) timeout_err <= 1'b1;
            else if (clear_err) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_b_powermonitor_scan_sequencer.sv
// Directed bench for the scan sequencer: behavioural threshold RAM and ADC, hand-computed
// expectations for window grading, timeout, enable drop and asynchronous reset.
module tb_b_powermonitor_scan_sequencer;

    localparam int NumConv = 4;
    localparam int DW      = 12;
    localparam int Settle  = 4;
    localparam int Tmo     = 10;
    localparam logic [4*DW-1:0] ThrWord = {12'd3500, 12'd3300, 12'd2700, 12'd2500};

    logic          clock = 1'b0;
    logic          reset_n, enable, clear_err;
    logic [4:0]    chan_sel, thr_addr;
    logic          thr_rd, adc_soc, warn, fault, eoc, timeout_err;
    logic [4*DW-1:0] thr_data = '0;
    logic          adc_done = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic [31:0]   pgood_bus;

    int tests_run = 0;
    int tests_failed = 0;
    int samp [0:3];
    int dly [0:3];
    logic stale_done = 1'b0;
    logic rd_seen = 1'b0;
    logic adc_busy = 1'b0;
    int adc_cnt = 0;
    logic [DW-1:0] adc_val = '0;
    logic [4:0] sel_log [$];
    int since_rd = 0;
    int soc_gap = -1;

    always #5 clock = ~clock;

    b_powermonitor_scan_sequencer #(
        .NumConverters(NumConv), .DataWidth(DW), .SettleCycles(Settle), .TimeoutCycles(Tmo)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .clear_err(clear_err),
        .chan_sel(chan_sel), .thr_rd(thr_rd), .thr_addr(thr_addr), .thr_data(thr_data),
        .adc_soc(adc_soc), .adc_done(adc_done), .adc_data(adc_data),
        .pgood_bus(pgood_bus), .warn(warn), .fault(fault), .eoc(eoc),
        .timeout_err(timeout_err)
    );

    // RAM data is only valid in the cycle after the strobe; the ADC answers dly[] cycles after soc
    always @(negedge clock) begin
        thr_data = rd_seen ? ThrWord : '0;
        rd_seen  = thr_rd;
        adc_done = stale_done;
        adc_data = '0;
        if (!reset_n) begin
            adc_busy = 1'b0;
        end else if (adc_soc) begin
            adc_val  = samp[chan_sel][DW-1:0];
            adc_cnt  = dly[chan_sel];
            adc_busy = (adc_cnt != 0);
        end else if (adc_busy) begin
            adc_cnt--;
            if (adc_cnt == 0) begin
                adc_done = 1'b1;
                adc_data = adc_val;
                adc_busy = 1'b0;
            end
        end
    end

    always @(negedge clock) begin
        since_rd++;
        if (thr_rd) begin
            sel_log.push_back(chan_sel);
            since_rd = 0;
        end
        if (adc_soc) soc_gap = since_rd;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input int value, input int delay);
        samp[ch] = value;
        dly[ch]  = delay;
    endtask

    task automatic waitEoc(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        while (!seen && cycles < 200) begin
            @(negedge clock);
            cycles++;
            if (eoc) seen = 1'b1;
        end
        checkOutput("eoc_seen", 32'(seen), 32'd1);
    endtask

    int cyc;
    int bvals [6]       = '{3300, 3500, 2500, 2501, 2700, 3000};
    logic [31:0] bpg [6] = '{32'hF, 32'hB, 32'hB, 32'hF, 32'hF, 32'hF};
    logic bw [6]        = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    logic bf [6]        = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        reset_n   = 1'b0;
        enable    = 1'b0;
        clear_err = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus(i, 3000, 3);
        repeat (3) @(negedge clock);
        checkOutput("rst_chan_sel", 32'(chan_sel), 0);
        checkOutput("rst_thr_addr", 32'(thr_addr), 0);
        checkOutput("rst_thr_rd", 32'(thr_rd), 0);
        checkOutput("rst_adc_soc", 32'(adc_soc), 0);
        checkOutput("rst_pgood", pgood_bus, 0);
        checkOutput("rst_flags", {28'd0, warn, fault, eoc, timeout_err}, 0);

        // Nominal scan
        reset_n = 1'b1;
        @(negedge clock);
        enable = 1'b1;
        waitEoc(cyc);
        checkOutput("nom_pgood", pgood_bus, 32'hF);
        checkOutput("nom_warn", 32'(warn), 0);
        checkOutput("nom_fault", 32'(fault), 0);
        waitEoc(cyc);
        checkOutput("nom_period", 32'(cyc), 36);
        checkOutput("soc_gap", 32'(soc_gap), Settle);
        @(negedge clock);
        checkOutput("eoc_width", 32'(eoc), 0);
        for (int i = 0; i < 5; i++)
            checkOutput($sformatf("chan_seq%0d", i),
                        (i < sel_log.size()) ? 32'(sel_log[i]) : 32'hFF, 32'(i % 4));

        // Window boundaries on channel 2
        for (int i = 0; i < 6; i++) begin
            applyStimulus(2, bvals[i], 3);
            waitEoc(cyc);
            checkOutput($sformatf("bnd%0d_pgood", bvals[i]), pgood_bus, bpg[i]);
            checkOutput($sformatf("bnd%0d_warn", bvals[i]), 32'(warn), 32'(bw[i]));
            checkOutput($sformatf("bnd%0d_fault", bvals[i]), 32'(fault), 32'(bf[i]));
        end

        // Timeout on channel 1
        applyStimulus(1, 3000, 0);
        waitEoc(cyc);
        checkOutput("tmo_period", 32'(cyc), 43);
        checkOutput("tmo_pgood", pgood_bus, 32'hD);
        checkOutput("tmo_fault", 32'(fault), 1);
        checkOutput("tmo_err", 32'(timeout_err), 1);
        applyStimulus(1, 3000, 3);
        waitEoc(cyc);
        checkOutput("tmo_recover_period", 32'(cyc), 36);
        checkOutput("tmo_recover_pgood", pgood_bus, 32'hF);
        checkOutput("tmo_err_sticky", 32'(timeout_err), 1);
        clear_err = 1'b1;
        @(negedge clock);
        clear_err = 1'b0;
        @(negedge clock);
        checkOutput("tmo_err_cleared", 32'(timeout_err), 0);

        // Done on the last allowed WAIT cycle
        applyStimulus(1, 3000, Tmo);
        waitEoc(cyc);
        checkOutput("race_pgood", pgood_bus, 32'hF);
        checkOutput("race_fault", 32'(fault), 0);
        waitEoc(cyc);
        checkOutput("race_period", 32'(cyc), 43);
        checkOutput("race_err", 32'(timeout_err), 0);

        // Enable drop during channel 1 settle
        applyStimulus(1, 3300, 3);
        applyStimulus(2, 3500, 3);
        begin
            int n;
            int eoc_cnt;
            int rd_cnt;
            n = 0;
            while (!(thr_rd && chan_sel == 5'd1) && n < 50) begin
                @(negedge clock);
                n++;
            end
            checkOutput("drop_found_ch1", 32'(thr_rd && chan_sel == 5'd1), 1);
            enable  = 1'b0;
            eoc_cnt = 0;
            rd_cnt  = 0;
            repeat (40) begin
                @(negedge clock);
                if (eoc) eoc_cnt++;
                if (thr_rd) rd_cnt++;
            end
            checkOutput("drop_no_eoc", 32'(eoc_cnt), 0);
            checkOutput("drop_idle", 32'(rd_cnt), 0);
            checkOutput("drop_chan_sel", 32'(chan_sel), 0);
            checkOutput("drop_warn", 32'(warn), 1);
            checkOutput("drop_fault", 32'(fault), 0);
            checkOutput("drop_pgood", pgood_bus, 32'hF);

            applyStimulus(1, 3000, 3);
            applyStimulus(2, 3000, 3);
            enable = 1'b1;
            n = 0;
            while (!thr_rd && n < 20) begin
                @(negedge clock);
                n++;
            end
            checkOutput("restart_rd", 32'(thr_rd), 1);
            checkOutput("restart_chan", 32'(chan_sel), 0);
            waitEoc(cyc);
            checkOutput("restart_warn", 32'(warn), 0);
            checkOutput("restart_pgood", pgood_bus, 32'hF);

            // Asynchronous reset while waiting on channel 2
            n = 0;
            while (!(adc_soc && chan_sel == 5'd2) && n < 50) begin
                @(negedge clock);
                n++;
            end
            checkOutput("arst_found_soc", 32'(adc_soc && chan_sel == 5'd2), 1);
        end
        @(negedge clock);
        reset_n = 1'b0;
        enable  = 1'b0;
        #1;
        checkOutput("arst_chan_sel", 32'(chan_sel), 0);
        checkOutput("arst_pgood", pgood_bus, 0);
        checkOutput("arst_ctrl", {29'd0, thr_rd, adc_soc, eoc}, 0);
        checkOutput("arst_flags", {29'd0, warn, fault, timeout_err}, 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1 stale_done = 1'b1;
        @(posedge clock);
        #1 stale_done = 1'b0;
        repeat (5) @(negedge clock);
        checkOutput("stale_chan_sel", 32'(chan_sel), 0);
        checkOutput("stale_ctrl", {29'd0, thr_rd, adc_soc, eoc}, 0);
        checkOutput("stale_pgood", pgood_bus, 0);
        checkOutput("stale_flags", {29'd0, warn, fault, timeout_err}, 0);

        enable = 1'b1;
        waitEoc(cyc);
        checkOutput("post_rst_pgood", pgood_bus, 32'hF);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
